// File: rtl/complex_coef_apply_if.sv
// sc16 AXI-stream style beat: {I[31:16], Q[15:0]} with tlast and valid/ready handshake.
interface complex_coef_apply_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/complex_coef_apply.sv
// Per-packet sc16 complex coefficient multiply: one coefficient beat, then a packet of samples.
// Optional saturation counter port clip_cnt enabled by COMPLEX_COEF_APPLY_CLIP_CNT_EN.
module complex_coef_apply #(
    parameter int COEF_SHIFT = 14
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 clear,
    complex_coef_apply_if.slave  c,
    complex_coef_apply_if.slave  i,
    complex_coef_apply_if.master o
`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
    ,
    output logic [15:0]          clip_cnt
`endif
);
    localparam int STAGES = 3;
    localparam logic signed [33:0] RND = 34'sd1 <<< (COEF_SHIFT - 1);
    localparam logic signed [33:0] SAT_MAX = 34'sd32767;
    localparam logic signed [33:0] SAT_MIN = -34'sd32768;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               rst_done;
    logic               en, c_acc, i_acc;
    logic signed [15:0] coef_i, coef_q;
    logic [STAGES:1]    vld_pipe, last_pipe;
    logic signed [15:0] s1_di, s1_dq, s1_ci, s1_cq;
    logic signed [31:0] p_ii, p_qq, p_iq, p_qi;
    logic signed [33:0] sum_i, sum_q, sh_i, sh_q;
    logic [15:0]        res_i, res_q;
    logic               clip_i, clip_q;
    logic [31:0]        o_data_q;
    logic               unused_c_tlast;

    assign unused_c_tlast = c.tlast;

    // Whole pipeline moves as one; everything freezes while the output is stalled.
    assign en    = o.tready | ~vld_pipe[STAGES];
    assign c_acc = c.tvalid & c.tready;
    assign i_acc = i.tvalid & i.tready;

    always_comb begin
        state_d  = state_q;
        c.tready = 1'b0;
        i.tready = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    c.tready = rst_done & en;
                    if (c.tvalid & rst_done & en) state_d = RUN;
                end
                RUN: begin
                    i.tready = en;
                    if (i.tvalid & en & i.tlast) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            rst_done <= 1'b0;
            coef_i   <= '0;
            coef_q   <= '0;
        end else begin
            state_q  <= state_d;
            rst_done <= 1'b1;
            if (clear) begin
                coef_i <= '0;
                coef_q <= '0;
            end else if (c_acc) begin
                coef_i <= c.tdata[31:16];
                coef_q <= c.tdata[15:0];
            end
        end
    end

    // S3 combinational: full-precision sums, round half up, arithmetic shift, clamp.
    assign sum_i = p_ii - p_qq;
    assign sum_q = p_iq + p_qi;
    assign sh_i  = (sum_i + RND) >>> COEF_SHIFT;
    assign sh_q  = (sum_q + RND) >>> COEF_SHIFT;

    always_comb begin
        clip_i = (sh_i > SAT_MAX) || (sh_i < SAT_MIN);
        clip_q = (sh_q > SAT_MAX) || (sh_q < SAT_MIN);
        res_i  = (sh_i > SAT_MAX) ? 16'h7fff : (sh_i < SAT_MIN) ? 16'h8000 : sh_i[15:0];
        res_q  = (sh_q > SAT_MAX) ? 16'h7fff : (sh_q < SAT_MIN) ? 16'h8000 : sh_q[15:0];
    end

    // The coefficient rides with each sample so a new one can land while the last packet drains.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            s1_di     <= '0;
            s1_dq     <= '0;
            s1_ci     <= '0;
            s1_cq     <= '0;
            p_ii      <= '0;
            p_qq      <= '0;
            p_iq      <= '0;
            p_qi      <= '0;
            o_data_q  <= '0;
        end else if (clear) begin
            vld_pipe  <= '0;
        end else if (en) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], i_acc};
            last_pipe <= {last_pipe[STAGES-1:1], i.tlast};
            s1_di     <= i.tdata[31:16];
            s1_dq     <= i.tdata[15:0];
            s1_ci     <= coef_i;
            s1_cq     <= coef_q;
            p_ii      <= s1_di * s1_ci;
            p_qq      <= s1_dq * s1_cq;
            p_iq      <= s1_di * s1_cq;
            p_qi      <= s1_dq * s1_ci;
            o_data_q  <= {res_i, res_q};
        end
    end

    assign o.tdata  = o_data_q;
    assign o.tlast  = last_pipe[STAGES];
    assign o.tvalid = vld_pipe[STAGES];

`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            clip_cnt <= '0;
        end else if (clear) begin
            clip_cnt <= '0;
        end else if (en && vld_pipe[STAGES-1] && (clip_i || clip_q) && clip_cnt != 16'hffff) begin
            clip_cnt <= clip_cnt + 16'd1;
        end
    end
`else
    logic unused_clip;
    assign unused_clip = clip_i | clip_q;
`endif
endmodule

// File: tb/tb_complex_coef_apply.sv
// Bench for complex_coef_apply: directed cases plus random packets against a plain-arithmetic model.
module tb_complex_coef_apply;
    localparam int SH = 14;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    complex_coef_apply_if cif ();
    complex_coef_apply_if iif ();
    complex_coef_apply_if oif ();

    logic stall = 1'b0;
    logic bp_rand = 1'b0;
    logic rnd_ok = 1'b1;
    assign oif.tready = ~stall & (rnd_ok | ~bp_rand);

`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
    logic [15:0] clip_cnt;
`endif

    complex_coef_apply #(.COEF_SHIFT(SH)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .clear   (clear),
        .c       (cif.slave),
        .i       (iif.slave),
        .o       (oif.master)
`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
        ,
        .clip_cnt(clip_cnt)
`endif
    );

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int first_acc = 0;
    int last_acc = 0;
    int exp_clip = 0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          obs_cyc[$];
    logic [31:0] pkt_q[$];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rnd_ok <= ($urandom_range(0, 3) != 0);
    end

    // Outputs are sampled on the falling edge; handshake inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (oif.tvalid === 1'b1 && oif.tready === 1'b1) begin
            obs_q.push_back({oif.tlast, oif.tdata});
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: exact integer arithmetic, floor((p + 2^(SH-1)) / 2^SH), clamp to int16.
    function automatic logic [32:0] model(input logic [31:0] cf, input logic [31:0] d,
                                          input logic last, output logic clipped);
        longint ci, cq, di, dq, pi, pq;
        ci = longint'($signed(cf[31:16]));
        cq = longint'($signed(cf[15:0]));
        di = longint'($signed(d[31:16]));
        dq = longint'($signed(d[15:0]));
        pi = di * ci - dq * cq;
        pq = di * cq + dq * ci;
        pi = (pi + (longint'(1) <<< (SH - 1))) >>> SH;
        pq = (pq + (longint'(1) <<< (SH - 1))) >>> SH;
        clipped = 1'b0;
        if (pi > 32767) begin pi = 32767; clipped = 1'b1; end
        else if (pi < -32768) begin pi = -32768; clipped = 1'b1; end
        if (pq > 32767) begin pq = 32767; clipped = 1'b1; end
        else if (pq < -32768) begin pq = -32768; clipped = 1'b1; end
        return {last, pi[15:0], pq[15:0]};
    endfunction

    task automatic send_coef(input logic [31:0] cd);
        int n = 0;
        cif.tdata  = cd;
        cif.tvalid = 1'b1;
        @(negedge clk);
        while (cif.tready !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
        if (n >= 1000) begin total++; $display("FAIL coef_timeout got no c_tready want accept"); end
        @(posedge clk); #1;
        cif.tvalid = 1'b0;
    endtask

    task automatic send_pkt();
        for (int j = 0; j < pkt_q.size(); j++) begin
            int n = 0;
            iif.tdata  = pkt_q[j];
            iif.tlast  = (j == pkt_q.size() - 1);
            iif.tvalid = 1'b1;
            @(negedge clk);
            while (iif.tready !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
            if (n >= 1000) begin total++; $display("FAIL data_timeout got no i_tready want accept"); end
            if (j == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk); #1;
        end
        iif.tvalid = 1'b0;
        iif.tlast  = 1'b0;
    endtask

    task automatic wait_drain(input int ob, input int eb);
        int n = 0;
        while ((obs_q.size() - ob) < (exp_q.size() - eb) && n < 2000) begin n++; @(negedge clk); end
        if (n >= 2000) begin
            total++;
            $display("FAIL drain_timeout got %0d beats want %0d", obs_q.size() - ob, exp_q.size() - eb);
        end
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (oif.tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", oif.tvalid); else passed++;
        total++; if (oif.tdata !== 32'h0) $display("FAIL reset_tdata got %h want 0", oif.tdata); else passed++;
        total++; if (oif.tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", oif.tlast); else passed++;
        total++; if (cif.tready !== 1'b0) $display("FAIL reset_c_tready got %b want 0", cif.tready); else passed++;
        total++; if (iif.tready !== 1'b0) $display("FAIL reset_i_tready got %b want 0", iif.tready); else passed++;
`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
        total++; if (clip_cnt !== 16'h0) $display("FAIL reset_clip_cnt got %0d want 0", clip_cnt); else passed++;
`endif
        aresetn = 1'b1;
        @(negedge clk);
        total++; if (cif.tready !== 1'b1) $display("FAIL post_reset_c_tready got %b want 1", cif.tready); else passed++;
        total++; if (iif.tready !== 1'b0) $display("FAIL post_reset_i_tready got %b want 0", iif.tready); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        int ob = obs_q.size();
        int eb = exp_q.size();
        pkt_q.delete();
        for (int k = 0; k < 8; k++) begin
            pkt_q.push_back({16'(1 + k), 16'(-1 - k)});
            exp_q.push_back({(k == 7), 16'(1 + k), 16'(-1 - k)});
        end
        send_coef({16'd16384, 16'd0});
        send_pkt();
        wait_drain(ob, eb);
        total++; if (obs_q.size() - ob != 8) $display("FAIL ident_count got %0d want 8", obs_q.size() - ob); else passed++;
        for (int k = 0; k < 8 && ob + k < obs_q.size(); k++) begin
            total++;
            if (obs_q[ob + k] !== exp_q[eb + k]) $display("FAIL ident_beat%0d got %h want %h", k, obs_q[ob + k], exp_q[eb + k]);
            else passed++;
        end
        if (obs_q.size() > ob) begin
            total++;
            if (obs_cyc[ob] - first_acc != 3) $display("FAIL ident_latency got %0d want 3", obs_cyc[ob] - first_acc);
            else passed++;
        end
        total++; if (last_acc - first_acc != 7) $display("FAIL ident_throughput got %0d want 7", last_acc - first_acc); else passed++;
    endtask

    task automatic test_directed();
        int ob = obs_q.size();
        int eb = exp_q.size();
        // rotation by j
        pkt_q.delete(); pkt_q.push_back({16'd100, 16'd200});
        exp_q.push_back({1'b1, 16'hff38, 16'd100});
        send_coef({16'd0, 16'd16384});
        send_pkt();
        // rounding half up at half scale
        pkt_q.delete(); pkt_q.push_back({16'd3, 16'd0}); pkt_q.push_back({16'hfffd, 16'd0});
        exp_q.push_back({1'b0, 16'd2, 16'd0});
        exp_q.push_back({1'b1, 16'hffff, 16'd0});
        send_coef({16'd8192, 16'd0});
        send_pkt();
        // saturation
        pkt_q.delete(); pkt_q.push_back({16'h7fff, 16'h7fff});
        exp_q.push_back({1'b1, 16'h0000, 16'h7fff});
        exp_clip++;
        send_coef({16'd16384, 16'd16384});
        send_pkt();
        wait_drain(ob, eb);
        total++; if (obs_q.size() - ob != 4) $display("FAIL directed_count got %0d want 4", obs_q.size() - ob); else passed++;
        for (int k = 0; k < 4 && ob + k < obs_q.size(); k++) begin
            total++;
            if (obs_q[ob + k] !== exp_q[eb + k]) $display("FAIL directed_beat%0d got %h want %h", k, obs_q[ob + k], exp_q[eb + k]);
            else passed++;
        end
`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
        total++; if (clip_cnt !== 16'(exp_clip)) $display("FAIL sat_clip_cnt got %0d want %0d", clip_cnt, exp_clip); else passed++;
`endif
    endtask

    task automatic test_backpressure();
        int ob = obs_q.size();
        int eb = exp_q.size();
        pkt_q.delete();
        for (int k = 0; k < 16; k++) begin
            logic [31:0] d;
            d = $urandom;
            pkt_q.push_back(d);
            exp_q.push_back({(k == 15), d});
        end
        send_coef({16'd16384, 16'd0});
        fork
            send_pkt();
            begin
                int n = 0;
                logic [31:0] sd;
                logic sl;
                while ((obs_q.size() - ob) < 4 && n < 500) begin n++; @(negedge clk); end
                @(posedge clk); #1;
                stall = 1'b1;
                @(negedge clk);
                sd = oif.tdata;
                sl = oif.tlast;
                total++; if (iif.tready !== 1'b0) $display("FAIL stall_i_tready got %b want 0", iif.tready); else passed++;
                repeat (4) begin
                    @(negedge clk);
                    total++; if (oif.tvalid !== 1'b1) $display("FAIL stall_tvalid got %b want 1", oif.tvalid); else passed++;
                    total++; if (oif.tdata !== sd || oif.tlast !== sl)
                        $display("FAIL stall_hold got %h/%b want %h/%b", oif.tdata, oif.tlast, sd, sl); else passed++;
                end
                @(posedge clk); #1;
                stall = 1'b0;
            end
        join
        wait_drain(ob, eb);
        total++; if (obs_q.size() - ob != 16) $display("FAIL bp_count got %0d want 16", obs_q.size() - ob); else passed++;
        for (int k = 0; k < 16 && ob + k < obs_q.size(); k++) begin
            total++;
            if (obs_q[ob + k] !== exp_q[eb + k]) $display("FAIL bp_beat%0d got %h want %h", k, obs_q[ob + k], exp_q[eb + k]);
            else passed++;
        end
    endtask

    task automatic test_multipacket();
        int ob = obs_q.size();
        int eb = exp_q.size();
        int la1;
        logic [31:0] cf [2];
        logic cl;
        cf[0] = {16'd16384, 16'd0};
        cf[1] = {16'hc000, 16'd0};
        for (int p = 0; p < 2; p++) begin
            pkt_q.delete();
            for (int k = 0; k < 4; k++) begin
                pkt_q.push_back($urandom);
                exp_q.push_back(model(cf[p], pkt_q[k], (k == 3), cl));
                if (cl) exp_clip++;
            end
            iif.tdata  = pkt_q[0];
            iif.tvalid = 1'b1;
            @(negedge clk);
            total++; if (iif.tready !== 1'b0) $display("FAIL pre_coef_i_tready pkt%0d got %b want 0", p, iif.tready); else passed++;
            @(posedge clk); #1;
            la1 = last_acc;
            send_coef(cf[p]);
            send_pkt();
            if (p == 1) begin
                total++; if (first_acc - la1 < 2) $display("FAIL pkt_bubble got %0d want >=2", first_acc - la1); else passed++;
            end
        end
        wait_drain(ob, eb);
        total++; if (obs_q.size() - ob != 8) $display("FAIL multi_count got %0d want 8", obs_q.size() - ob); else passed++;
        for (int k = 0; k < 8 && ob + k < obs_q.size(); k++) begin
            total++;
            if (obs_q[ob + k] !== exp_q[eb + k]) $display("FAIL multi_beat%0d got %h want %h", k, obs_q[ob + k], exp_q[eb + k]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int ob = obs_q.size();
        int eb = exp_q.size();
        int cnt = 0;
        logic cl;
        bp_rand = 1'b1;
        for (int p = 0; p < 6; p++) begin
            logic [31:0] cf;
            int len;
            cf  = $urandom;
            len = $urandom_range(1, 10);
            pkt_q.delete();
            for (int k = 0; k < len; k++) begin
                pkt_q.push_back($urandom);
                exp_q.push_back(model(cf, pkt_q[k], (k == len - 1), cl));
                if (cl) exp_clip++;
            end
            cnt += len;
            send_coef(cf);
            send_pkt();
        end
        wait_drain(ob, eb);
        bp_rand = 1'b0;
        total++; if (obs_q.size() - ob != cnt) $display("FAIL rand_count got %0d want %0d", obs_q.size() - ob, cnt); else passed++;
        for (int k = 0; k < cnt && ob + k < obs_q.size(); k++) begin
            total++;
            if (obs_q[ob + k] !== exp_q[eb + k]) $display("FAIL rand_beat%0d got %h want %h", k, obs_q[ob + k], exp_q[eb + k]);
            else passed++;
        end
`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
        total++; if (clip_cnt !== 16'(exp_clip)) $display("FAIL rand_clip_cnt got %0d want %0d", clip_cnt, exp_clip); else passed++;
`endif
    endtask

    task automatic test_clear();
        int os;
        int ob;
        int eb;
        logic cl;
        logic [31:0] cf;
        send_coef({16'd16384, 16'd0});
        iif.tvalid = 1'b1;
        iif.tlast  = 1'b0;
        iif.tdata  = 32'h0011_0022;
        repeat (3) begin
            @(posedge clk); #1;
            iif.tdata = iif.tdata + 32'h0001_0001;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        iif.tvalid = 1'b0;
        exp_clip = 0;
        @(negedge clk);
        total++; if (oif.tvalid !== 1'b0) $display("FAIL clear_tvalid got %b want 0", oif.tvalid); else passed++;
        total++; if (cif.tready !== 1'b1) $display("FAIL clear_c_tready got %b want 1", cif.tready); else passed++;
        total++; if (iif.tready !== 1'b0) $display("FAIL clear_i_tready got %b want 0", iif.tready); else passed++;
`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
        total++; if (clip_cnt !== 16'h0) $display("FAIL clear_clip_cnt got %0d want 0", clip_cnt); else passed++;
`endif
        os = obs_q.size();
        repeat (5) @(negedge clk);
        total++; if (obs_q.size() != os) $display("FAIL clear_flush got %0d extra beats want 0", obs_q.size() - os); else passed++;
        @(posedge clk); #1;
        ob = obs_q.size();
        eb = exp_q.size();
        cf = $urandom;
        pkt_q.delete();
        for (int k = 0; k < 4; k++) begin
            pkt_q.push_back($urandom);
            exp_q.push_back(model(cf, pkt_q[k], (k == 3), cl));
            if (cl) exp_clip++;
        end
        send_coef(cf);
        send_pkt();
        wait_drain(ob, eb);
        total++; if (obs_q.size() - ob != 4) $display("FAIL post_clear_count got %0d want 4", obs_q.size() - ob); else passed++;
        for (int k = 0; k < 4 && ob + k < obs_q.size(); k++) begin
            total++;
            if (obs_q[ob + k] !== exp_q[eb + k]) $display("FAIL post_clear_beat%0d got %h want %h", k, obs_q[ob + k], exp_q[eb + k]);
            else passed++;
        end
`ifdef COMPLEX_COEF_APPLY_CLIP_CNT_EN
        total++; if (clip_cnt !== 16'(exp_clip)) $display("FAIL post_clear_clip_cnt got %0d want %0d", clip_cnt, exp_clip); else passed++;
`endif
    endtask

    initial begin
        cif.tdata  = '0;
        cif.tlast  = 1'b0;
        cif.tvalid = 1'b0;
        iif.tdata  = '0;
        iif.tlast  = 1'b0;
        iif.tvalid = 1'b0;
        test_reset();
        test_identity();
        test_directed();
        test_backpressure();
        test_multipacket();
        test_random();
        test_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
